// File: rtl/genesis_pad_emulator.sv
// Device-side emulation of a six-button Genesis-style gamepad.
// Samples the host-driven select line and drives the six active-low data pins.
// The six-button identification and extended-button phases are included.
//
// Parameters:
//   TIMEOUT_CYCLES : idle cycles after the last select falling edge before the
//                    phase counter returns to 0
//   SIX_BUTTON     : 1 = six-button protocol, 0 = three-button only
//
// Ports:
//   clk            : system clock
//   reset          : synchronous active-high reset
//   select         : host select line, asynchronous to clk
//   buttons[11:0]  : pressed = 1; up,down,left,right,a,b,c,x,y,z,start,mode (MSB..LSB)
//   PIN_UP_Z .. PIN_START_C : registered active-low data pins
//   phase[2:0]     : current falling-edge count (0..4)
module genesis_pad_emulator #(
    parameter int unsigned TIMEOUT_CYCLES = 75000,
    parameter int unsigned SIX_BUTTON     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [11:0] buttons,
    output logic        PIN_UP_Z,
    output logic        PIN_DOWN_Y,
    output logic        PIN_LEFT_X,
    output logic        PIN_RIGHT_MODE,
    output logic        PIN_A_B,
    output logic        PIN_START_C,
    output logic [2:0]  phase
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic          sel_s1, sel_s2, sel_d;
    logic [11:0]   btn_q;
    logic [2:0]    cnt, cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic [5:0]    pins_q, pins_next;
    logic          fall, expired;
    logic [2:0]    mux_cnt;

    // Button aliases on the registered vector
    logic b_up, b_down, b_left, b_right, b_a, b_b, b_c, b_x, b_y, b_z, b_start, b_mode;
    assign {b_up, b_down, b_left, b_right, b_a, b_b, b_c,
            b_x, b_y, b_z, b_start, b_mode} = btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_s1 <= 1'b1;
            sel_s2 <= 1'b1;
            sel_d  <= 1'b1;
            btn_q  <= '0;
            cnt    <= '0;
            timer  <= '0;
            pins_q <= '1;
        end else begin
            sel_s1 <= select;
            sel_s2 <= sel_s1;
            sel_d  <= sel_s2;
            btn_q  <= buttons;
            cnt    <= cnt_next;
            timer  <= timer_next;
            pins_q <= pins_next;
        end
    end

    // Phase counter and idle timer
    always_comb begin
        fall       = sel_d & ~sel_s2;
        expired    = (timer == TMAX);
        cnt_next   = cnt;
        timer_next = timer;
        if (fall) begin
            timer_next = '0;
            // An edge landing on expiry starts a fresh frame rather than continuing the old one
            if (expired) begin
                cnt_next = 3'd1;
            end else if (cnt >= 3'd4) begin
                cnt_next = 3'd4;
            end else begin
                cnt_next = cnt + 3'd1;
            end
        end else if (expired) begin
            cnt_next = '0;
        end else begin
            timer_next = timer + 1'b1;
        end
    end

    // Pin mux; uses next-cnt so the pins track the phase set by this same edge
    always_comb begin
        mux_cnt   = (SIX_BUTTON != 0) ? cnt_next : 3'd1;
        pins_next = ~{b_up, b_down, b_left, b_right, b_b, b_c};
        if (!sel_s2) begin
            case (mux_cnt)
                3'd3:    pins_next = {4'b0000, ~b_a, ~b_start};
                3'd4:    pins_next = {4'b1111, ~b_a, ~b_start};
                default: pins_next = {~b_up, ~b_down, 2'b00, ~b_a, ~b_start};
            endcase
        end else if (mux_cnt == 3'd3) begin
            pins_next = ~{b_z, b_y, b_x, b_mode, b_b, b_c};
        end
    end

    assign {PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C} = pins_q;
    assign phase = cnt;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
module tb_genesis_pad_emulator;

    logic        clk;
    logic        reset;
    logic        select;
    logic [11:0] buttons;

    logic       s_up, s_down, s_left, s_right, s_ab, s_sc;
    logic [2:0] s_phase;
    logic       t_up, t_down, t_left, t_right, t_ab, t_sc;
    logic [2:0] t_phase;

    logic [5:0] pins6, pins3;
    assign pins6 = {s_up, s_down, s_left, s_right, s_ab, s_sc};
    assign pins3 = {t_up, t_down, t_left, t_right, t_ab, t_sc};

    int total = 0;
    int bad   = 0;

    genesis_pad_emulator #(.TIMEOUT_CYCLES(100), .SIX_BUTTON(1)) dut6 (
        .clk(clk), .reset(reset), .select(select), .buttons(buttons),
        .PIN_UP_Z(s_up), .PIN_DOWN_Y(s_down), .PIN_LEFT_X(s_left),
        .PIN_RIGHT_MODE(s_right), .PIN_A_B(s_ab), .PIN_START_C(s_sc),
        .phase(s_phase)
    );

    genesis_pad_emulator #(.TIMEOUT_CYCLES(100), .SIX_BUTTON(0)) dut3 (
        .clk(clk), .reset(reset), .select(select), .buttons(buttons),
        .PIN_UP_Z(t_up), .PIN_DOWN_Y(t_down), .PIN_LEFT_X(t_left),
        .PIN_RIGHT_MODE(t_right), .PIN_A_B(t_ab), .PIN_START_C(t_sc),
        .phase(t_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [11:0] btn;
        logic [5:0]  exp6;
        logic [5:0]  exp3;
        logic [2:0]  ph;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling/driving
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        select = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Two falling edges spaced gap posedges apart; check resulting phase
    task automatic edge_gap(input int gap, input int exp_ph);
        do_reset();
        buttons = 12'h000;
        select = 1'b0;
        step(5);
        select = 1'b1;
        step(gap - 5);
        select = 1'b0;
        step(4);
        check($sformatf("edge_gap%0d_phase", gap), int'(s_phase), exp_ph);
    endtask

    initial begin
        //               sel   btn      six-button  three-button phase
        vecs[0]  = '{1'b1, 12'h820, 6'b011110, 6'b011110, 3'd0};
        vecs[1]  = '{1'b0, 12'h082, 6'b110000, 6'b110000, 3'd1};
        vecs[2]  = '{1'b1, 12'h015, 6'b111111, 6'b111111, 3'd1};
        vecs[3]  = '{1'b0, 12'h015, 6'b110011, 6'b110011, 3'd2};
        vecs[4]  = '{1'b1, 12'h015, 6'b111111, 6'b111111, 3'd2};
        vecs[5]  = '{1'b0, 12'h015, 6'b000011, 6'b110011, 3'd3};
        vecs[6]  = '{1'b1, 12'h015, 6'b010011, 6'b111111, 3'd3};
        vecs[7]  = '{1'b0, 12'h015, 6'b111111, 6'b110011, 3'd4};
        vecs[8]  = '{1'b1, 12'h015, 6'b111111, 6'b111111, 3'd4};
        vecs[9]  = '{1'b0, 12'h015, 6'b111111, 6'b110011, 3'd4};
        vecs[10] = '{1'b1, 12'hFFF, 6'b000000, 6'b000000, 3'd4};
        vecs[11] = '{1'b0, 12'hFFF, 6'b111100, 6'b000000, 3'd4};

        reset = 1'b1;
        select = 1'b0;
        buttons = 12'hFFF;
        step(3);
        check("reset_pins6", int'(pins6), 'h3F);
        check("reset_pins3", int'(pins3), 'h3F);
        check("reset_phase", int'(s_phase), 0);
        reset = 1'b0;
        select = 1'b1;

        for (int i = 0; i < 12; i++) begin
            select  = vecs[i].sel;
            buttons = vecs[i].btn;
            step(10);
            check($sformatf("vec%0d_pins6", i), int'(pins6), int'(vecs[i].exp6));
            check($sformatf("vec%0d_pins3", i), int'(pins3), int'(vecs[i].exp3));
            check($sformatf("vec%0d_phase6", i), int'(s_phase), int'(vecs[i].ph));
            check($sformatf("vec%0d_phase3", i), int'(t_phase), int'(vecs[i].ph));
        end

        // Reset mid-sequence with select low: next cycle shows reset values
        reset = 1'b1;
        step(1);
        check("midreset_pins6", int'(pins6), 'h3F);
        check("midreset_phase", int'(s_phase), 0);

        // Timeout: two pulses, idle, then a fresh frame
        do_reset();
        buttons = 12'h015;
        for (int p = 0; p < 2; p++) begin
            select = 1'b0;
            step(5);
            select = 1'b1;
            step(5);
        end
        check("to_phase_after2", int'(s_phase), 2);
        step(80);
        check("to_phase_before_expiry", int'(s_phase), 2);
        step(30);
        check("to_phase_expired", int'(s_phase), 0);
        for (int p = 0; p < 3; p++) begin
            select = 1'b0;
            step(5);
            if (p == 1) check("to_2nd_low_pins", int'(pins6), 'b110011);
            if (p == 2) begin
                check("to_3rd_low_pins", int'(pins6), 'b000011);
                check("to_3rd_low_phase", int'(s_phase), 3);
            end
            select = 1'b1;
            step(5);
        end

        // Second edge one cycle before expiry, then exactly on expiry
        edge_gap(100, 2);
        edge_gap(101, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
